// File: rtl/mcu_subsys_bus_decoder_if.sv
// Purpose : native memory bus bundle (request valid/addr/wdata/wstrb, response ready/rdata)
//           shared by the CPU port and both downstream slave ports of the bus decoder.
// Ports   : valid, addr[31:0], wdata[31:0], wstrb[3:0] flow master->slave; ready, rdata[31:0] flow back.
//           wstrb == 0 marks a read. ready is a one-cycle completion pulse, rdata valid with it.
interface mcu_subsys_bus_decoder_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mcu_subsys_bus_decoder.sv
// Purpose : decodes CPU native-bus requests to the SRAM window, the peripheral window or unmapped,
//           forwards to exactly one slave and returns its response; sticky error capture.
// Ports   : clk, rst_n (async, active-low); cpu (slave side of CPU bus); sram, per (master side
//           towards slaves; sram.addr carries a word index); err_clr in; bus_err, err_addr out.
// Latency : SRAM 3 cycles, unmapped 1 cycle, peripheral 2 + slave ready latency (valid to ready).
// Config  : define MCU_BUS_TIMEOUT_EN to abort a slave wait after TIMEOUT_CYCLES cycles.
module mcu_subsys_bus_decoder #(
  parameter logic [31:0] SRAM_BASE      = 32'h0000_0000,
  parameter int unsigned SRAM_BYTES     = 1024,
  parameter logic [31:0] PER_BASE       = 32'h8000_0000,
  parameter logic [31:0] PER_BYTES      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  mcu_subsys_bus_decoder_if.slave         cpu,
  mcu_subsys_bus_decoder_if.master        sram,
  mcu_subsys_bus_decoder_if.master        per,
  input  logic                            err_clr,
  output logic                            bus_err,
  output logic [31:0]                     err_addr
);

  if (SRAM_BYTES < 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mcu_subsys_bus_decoder: SRAM_BYTES must be >= 4 and TIMEOUT_CYCLES >= 2");
  end

  localparam logic [31:0] SRAM_MASK = 32'(SRAM_BYTES - 1);
  localparam logic [31:0] PER_MASK  = PER_BYTES - 32'd1;

  typedef enum logic [2:0] {IDLE, SRAM_WAIT, PER_WAIT, ERR, TURN} state_e;

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sram_vld_q, sram_vld_d;
  logic [31:0] sram_addr_q, sram_addr_d;
  logic [31:0] sram_wdata_q, sram_wdata_d;
  logic [3:0]  sram_wstrb_q, sram_wstrb_d;
  logic        per_vld_q, per_vld_d;
  logic [31:0] per_addr_q, per_addr_d;
  logic [31:0] per_wdata_q, per_wdata_d;
  logic [3:0]  per_wstrb_q, per_wstrb_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  // Byte address of the request in flight; sram_addr only holds a word index, and a timeout
  // must still report the byte address.
  logic [31:0] req_addr_q, req_addr_d;

  logic        hit_sram, hit_per;
  logic        slv_rdy;
  logic [31:0] slv_rdata;

  // Bases are aligned to their sizes, so a masked compare is an exact window test.
  assign hit_sram  = (cpu.addr & ~SRAM_MASK) == SRAM_BASE;
  assign hit_per   = (cpu.addr & ~PER_MASK) == PER_BASE;
  assign slv_rdy   = (state_q == SRAM_WAIT) ? sram.ready : per.ready;
  assign slv_rdata = (state_q == SRAM_WAIT) ? sram.rdata : per.rdata;

`ifdef MCU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b0;
      rdata_q      <= '0;
      sram_vld_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_wstrb_q <= '0;
      per_vld_q    <= 1'b0;
      per_addr_q   <= '0;
      per_wdata_q  <= '0;
      per_wstrb_q  <= '0;
      bus_err_q    <= 1'b0;
      err_addr_q   <= '0;
      req_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      rdata_q      <= rdata_d;
      sram_vld_q   <= sram_vld_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_wstrb_q <= sram_wstrb_d;
      per_vld_q    <= per_vld_d;
      per_addr_q   <= per_addr_d;
      per_wdata_q  <= per_wdata_d;
      per_wstrb_q  <= per_wstrb_d;
      bus_err_q    <= bus_err_d;
      err_addr_q   <= err_addr_d;
      req_addr_q   <= req_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rdy_d        = 1'b0;
    rdata_d      = rdata_q;
    sram_vld_d   = sram_vld_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_wstrb_d = sram_wstrb_q;
    per_vld_d    = per_vld_q;
    per_addr_d   = per_addr_q;
    per_wdata_d  = per_wdata_q;
    per_wstrb_d  = per_wstrb_q;
    // A clear and a new error in the same cycle: the error assignment below overrides.
    bus_err_d    = err_clr ? 1'b0 : bus_err_q;
    err_addr_d   = err_addr_q;
    req_addr_d   = req_addr_q;
`ifdef MCU_BUS_TIMEOUT_EN
    cnt_d        = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cpu.valid) begin
          req_addr_d = cpu.addr;
          if (hit_sram) begin
            sram_vld_d   = 1'b1;
            sram_addr_d  = (cpu.addr & SRAM_MASK) >> 2;
            sram_wdata_d = cpu.wdata;
            sram_wstrb_d = cpu.wstrb;
            state_d      = SRAM_WAIT;
          end else if (hit_per) begin
            per_vld_d    = 1'b1;
            per_addr_d   = cpu.addr;
            per_wdata_d  = cpu.wdata;
            per_wstrb_d  = cpu.wstrb;
            state_d      = PER_WAIT;
          end else begin
            // Unmapped: answer straight away; the ERR cycle is the one presenting the response.
            rdy_d      = 1'b1;
            rdata_d    = ERR_RDATA;
            bus_err_d  = 1'b1;
            err_addr_d = cpu.addr;
            state_d    = ERR;
          end
        end
      end
      SRAM_WAIT, PER_WAIT: begin
        if (slv_rdy) begin
          rdy_d      = 1'b1;
          rdata_d    = slv_rdata;
          sram_vld_d = 1'b0;
          per_vld_d  = 1'b0;
          state_d    = TURN;
        end
`ifdef MCU_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdy_d      = 1'b1;
          rdata_d    = ERR_RDATA;
          sram_vld_d = 1'b0;
          per_vld_d  = 1'b0;
          bus_err_d  = 1'b1;
          err_addr_d = req_addr_q;
          state_d    = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ERR:     state_d = TURN;
      // The CPU still holds valid here and SRAM ready may be a stale repeat; ignore both.
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cpu.ready  = rdy_q;
  assign cpu.rdata  = rdata_q;
  assign sram.valid = sram_vld_q;
  assign sram.addr  = sram_addr_q;
  assign sram.wdata = sram_wdata_q;
  assign sram.wstrb = sram_wstrb_q;
  assign per.valid  = per_vld_q;
  assign per.addr   = per_addr_q;
  assign per.wdata  = per_wdata_q;
  assign per.wstrb  = per_wstrb_q;
  assign bus_err    = bus_err_q;
  assign err_addr   = err_addr_q;

endmodule
